pattern_scan_ctrl: RTL and testbench
====================================

Name: pattern_scan_ctrl

Overview:
Session controller that sequences a serial pattern-detection datapath from a parallel word stream. It accepts words over a valid/ready handshake and serialises each word MSB-first into a programmable-pattern detector. It counts matches, in overlapping or non-overlapping mode, and reports end of session. It sits between a byte/word source and the sequence-detector logic, replacing hand-driven din sequencing.

Parameters:
DATA_W, 8, width of each input word (>=2)
PAT_W, 4, pattern length in bits (2..DATA_W)
CNT_W, 8, match counter width

Ports:
clk  input  1  rising-edge clock, only clock domain
reset  input  1  synchronous, active-high reset
start  input  1  begin session; sampled only in IDLE
pattern  input  PAT_W  target pattern, MSB = first bit in time; latched on accepted start
overlap  input  1  1 = overlapping matches allowed; latched on accepted start
in_valid  input  1  word available
in_data  input  DATA_W  word, shifted out MSB first
in_last  input  1  qualifies in_data as final word of session
in_ready  output  1  controller accepts word this cycle
detected  output  1  one-cycle pulse per match, registered
match_count  output  CNT_W  matches this session, saturating
busy  output  1  high in LOAD and SHIFT
done  output  1  one-cycle pulse at end of session

Behaviour:
- Reset (synchronous, active-high): state=IDLE. in_ready, detected, done, busy = 0. match_count = 0. History, fill, bit index and latched pattern are cleared. Reset asserted mid-session aborts the session with no done pulse.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: in_ready=0. start=1 latches pattern/overlap, clears match_count, history and fill, and moves to LOAD next cycle. match_count holds the previous session's value until start.
- LOAD: in_ready=1 combinationally. in_valid&in_ready captures in_data and in_last, sets bit_idx=DATA_W-1 and moves to SHIFT. in_valid=0 stays in LOAD indefinitely with no history change.
- SHIFT: in_ready=0. Each cycle consumes bit b=word[bit_idx]. Next history = {history[PAT_W-2:0], b}. fill increments, saturating at PAT_W.
- Match: (next history == pattern) and (fill+1 >= PAT_W).
- On match, at the same edge: detected<=1 (high the cycle after the bit is consumed) and match_count increments, saturating at 2^CNT_W-1. Otherwise detected<=0.
- On match with overlap=0, fill<=0, so history bits are not reused. With overlap=1, fill is unchanged.
- bit_idx==0: next state is DONE if latched last=1, else LOAD.
- History and fill persist across words, so patterns spanning word boundaries are detected.
- DONE: done=1 for exactly one cycle. A detected pulse for the final bit coincides with done, and match_count is final in this cycle. Next state is IDLE.
- start outside IDLE is ignored.
- Throughput: 1 handshake cycle + DATA_W shift cycles per word, minimum DATA_W+1 cycles per word.
- busy = (state==LOAD || state==SHIFT).

Decomposition:
- Shared package pattern_scan_pkg: state encoding localparams (IDLE=2'b00, LOAD=2'b01, SHIFT=2'b10, DONE=2'b11) and default widths.
- Sub-module pattern_match_core: history shift register, fill counter, match compare and overlap clear. Inputs: bit, bit_en, clear, pattern, overlap. Output: match.
- pattern_scan_ctrl holds the FSM, word/bit-index registers, counter and handshake.

Test Plan:
1. pattern=4'b1010, overlap=1, one word 8'b1010_1010 with last=1 -> detected pulses after shift bits 4, 6 and 8 (3 pulses); done with match_count=3.
2. Same stimulus with overlap=0 -> pulses after bits 4 and 8 only; match_count=2 at done.
3. pattern=4'b1010, words 8'b0000_0101 (last=0) then 8'b0000_0000 (last=1) -> one pulse, on the first bit of the second word; match_count=1.
4. Backpressure: in LOAD, hold in_valid=0 for 5 cycles -> in_ready stays 1, state stays LOAD, no detected, match_count unchanged; the word is then accepted on the first in_valid cycle.
5. Saturation, CNT_W=2, pattern=2'b11 (PAT_W=2), overlap=1, word 8'hFF last=1 -> 7 detected pulses; match_count stops at 3.
6. Reset mid-SHIFT (bit 3 of a word), then start a new session -> next cycle all outputs are 0 and state is IDLE with no done. The next session starts with cleared history, so no match spans the reset.

Source files
------------

// File: rtl/pattern_scan_pkg.sv
// rtl/pattern_scan_pkg.sv - shared state encoding and default widths for the pattern scan controller
// Contents: state_t (IDLE/LOAD/SHIFT/DONE) and the default DATA_W, PAT_W, CNT_W values.
package pattern_scan_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/pattern_match_core.sv
// rtl/pattern_match_core.sv - serial history register, fill counter and pattern compare
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   data_bit       serial bit consumed when bit_en is high
//   bit_en         consume data_bit this cycle
//   clear          drop history and fill (session start)
//   pattern        target pattern, MSB is the earliest bit in time
//   overlap        1 = history bits may be reused by the next match
//   match          combinational: the bit being consumed completes the pattern
module pattern_match_core #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_bit,
  input  logic             bit_en,
  input  logic             clear,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  next_history;
  logic [FILL_W-1:0] fill;

  assign next_history = {history[PAT_W-2:0], data_bit};

  // fill >= PAT_W-1 is the same as fill+1 >= PAT_W: the incoming bit makes
  // the window full, so a stale or previously used history cannot match.
  assign match = bit_en && (next_history == pattern) && (fill >= FILL_ARM);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      history <= '0;
      fill    <= '0;
    end else if (bit_en) begin
      history <= next_history;
      if (match && !overlap) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - session FSM that serialises words MSB-first into the pattern matcher
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   start            begin a session (IDLE only); latches pattern and overlap
//   pattern/overlap  session configuration
//   in_valid/in_data/in_last/in_ready  word handshake, in_last marks the final word
//   detected         registered one-cycle pulse per match
//   match_count      saturating per-session match count
//   busy             high in LOAD and SHIFT
//   done             one-cycle pulse at end of session
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              detected,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t             state;
  logic [DATA_W-1:0]  word;
  logic               word_last;
  logic [IDX_W-1:0]   bit_idx;
  logic [PAT_W-1:0]   pat_q;
  logic               ovl_q;
  logic               match;

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD) || (state == SHIFT);

  pattern_match_core #(
    .PAT_W (PAT_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .data_bit (word[bit_idx]),
    .bit_en   (state == SHIFT),
    .clear    ((state == IDLE) && start),
    .pattern  (pat_q),
    .overlap  (ovl_q),
    .match    (match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      word        <= '0;
      word_last   <= 1'b0;
      bit_idx     <= '0;
      pat_q       <= '0;
      ovl_q       <= 1'b0;
      match_count <= '0;
      detected    <= 1'b0;
      done        <= 1'b0;
    end else begin
      detected <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pat_q       <= pattern;
            ovl_q       <= overlap;
            match_count <= '0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            word      <= in_data;
            word_last <= in_last;
            bit_idx   <= LAST_IDX;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (match) begin
            detected <= 1'b1;
            if (match_count != '1) begin
              match_count <= match_count + CNT_W'(1);
            end
          end
          if (bit_idx == '0) begin
            // done is raised on entry so it lines up with the final bit's detected pulse
            if (word_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end else begin
            bit_idx <= bit_idx - IDX_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - directed self-checking bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       overlap;
  logic       in_valid;
  logic       in_last;
  logic [3:0] pattern;
  logic [1:0] pattern2;
  logic [7:0] in_data;

  logic       in_ready,  detected,  busy,  done;
  logic [7:0] match_count;
  logic       in_ready2, detected2, busy2, done2;
  logic [1:0] match_count2;

  int passed = 0;
  int total  = 0;

  logic [7:0] m, m2, c;
  logic [1:0] c2;
  logic       dn;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .overlap(overlap),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .detected(detected), .match_count(match_count), .busy(busy), .done(done)
  );

  pattern_scan_ctrl #(.DATA_W(8), .PAT_W(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern2), .overlap(overlap),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready2),
    .detected(detected2), .match_count(match_count2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at a negedge while IDLE; returns at the negedge after entering LOAD.
  task automatic do_start(input logic [3:0] p, input logic [1:0] p2, input logic ov);
    start = 1'b1; pattern = p; pattern2 = p2; overlap = ov;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge in LOAD. Bit k of the masks is detected after shift bit k+1.
  task automatic send_word(input logic [7:0] d, input logic l,
                           output logic [7:0] mk, output logic [7:0] mk2,
                           output logic dn_o, output logic [7:0] cnt, output logic [1:0] cnt2);
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clk);
    in_valid = 1'b0;
    mk = '0; mk2 = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      mk[k]  = detected;
      mk2[k] = detected2;
    end
    dn_o = done;
    cnt  = match_count;
    cnt2 = match_count2;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; overlap = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    pattern = '0; pattern2 = '0; in_data = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_detected", detected, 0);
    check("rst_count", match_count, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);

    // 1: overlapping, 1010 in 1010_1010
    do_start(4'b1010, 2'b00, 1'b1);
    check("t1_load_ready", in_ready, 1);
    check("t1_load_busy", busy, 1);
    send_word(8'hAA, 1'b1, m, m2, dn, c, c2);
    check("t1_mask", m, 8'hA8);
    check("t1_done", dn, 1);
    check("t1_count", c, 3);
    @(negedge clk);
    check("t1_done_clear", done, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_count_hold", match_count, 3);

    // 2: non-overlapping
    do_start(4'b1010, 2'b00, 1'b0);
    check("t2_count_cleared", match_count, 0);
    send_word(8'hAA, 1'b1, m, m2, dn, c, c2);
    check("t2_mask", m, 8'h88);
    check("t2_done", dn, 1);
    check("t2_count", c, 2);
    @(negedge clk);

    // 3: match spanning a word boundary
    do_start(4'b1010, 2'b00, 1'b1);
    send_word(8'h05, 1'b0, m, m2, dn, c, c2);
    check("t3_w0_mask", m, 8'h00);
    check("t3_w0_no_done", dn, 0);
    check("t3_back_in_load", in_ready, 1);
    send_word(8'h00, 1'b1, m, m2, dn, c, c2);
    check("t3_w1_mask", m, 8'h01);
    check("t3_done", dn, 1);
    check("t3_count", c, 1);
    @(negedge clk);

    // 4: backpressure in LOAD, with a stray start and new pattern that must be ignored
    do_start(4'b1010, 2'b00, 1'b1);
    start = 1'b1; pattern = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_ready_hold", in_ready, 1);
      check("t4_busy_hold", busy, 1);
      check("t4_no_detect", detected, 0);
    end
    check("t4_count_hold", match_count, 0);
    start = 1'b0;
    send_word(8'hAA, 1'b1, m, m2, dn, c, c2);
    check("t4_mask", m, 8'hA8);
    check("t4_count", c, 3);
    @(negedge clk);

    // 5: saturation on the CNT_W=2, PAT_W=2 instance
    do_start(4'b0000, 2'b11, 1'b1);
    send_word(8'hFF, 1'b1, m, m2, dn, c, c2);
    check("t5_mask2", m2, 8'hFE);
    check("t5_count2_sat", c2, 3);
    check("t5_done2", done2, 1);
    check("t5_main_mask", m, 8'h00);
    @(negedge clk);

    // 6: reset after 3 bits of 1010_0000, then a fresh session on 0100_0000
    do_start(4'b1010, 2'b00, 1'b1);
    in_valid = 1'b1; in_data = 8'hA0; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_ready", in_ready, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_detected", detected, 0);
    check("t6_count", match_count, 0);
    @(negedge clk);
    check("t6_no_late_done", done, 0);
    check("t6_still_idle", busy, 0);
    do_start(4'b1010, 2'b00, 1'b1);
    send_word(8'h40, 1'b1, m, m2, dn, c, c2);
    check("t6_mask", m, 8'h00);
    check("t6_count_after", c, 0);
    check("t6_done_after", dn, 1);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
